// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_pipe
// Purpose  : Parametrised 3-stage pipelined floating-point adder/subtractor
//            (sign | EXP_W exponent | MAN_W fraction, hidden bit implicit).
//            Subnormal inputs flush to signed zero; results are rounded to
//            nearest, ties to even; underflow flushes to signed zero.
//            Stage 1 aligns, stage 2 adds, stage 3 normalises and rounds into
//            the registered outputs. All stages advance together when the
//            output register is empty or being drained.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            in_valid/in_ready, a, b, operation (0 add, 1 sub), in_tag
//            out_valid/out_ready, result, flags {ovf,unf,dz,inv,inx}, out_tag
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_pipe #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   operation,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [4:0]             flags,
    output logic [TAG_W-1:0]       out_tag
);

    // Extended significand: {hidden, fraction, guard, round, sticky}
    localparam int c_XW  = MAN_W + 4;
    localparam int c_MW  = MAN_W + 2;
    localparam int c_LZW = $clog2(c_XW + 1);
    // Signed working exponent, wide enough for exp - lzc and exp + 2
    localparam int c_EW  = ((EXP_W > c_LZW) ? EXP_W : c_LZW) + 2;
    localparam logic [EXP_W-1:0] c_EXP_ONES = '1;
    localparam logic [c_EW-1:0]  c_EXP_INF  = c_EW'((1 << EXP_W) - 1);

    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // ------------------------------------------------------------------
    // Stage 1: classify, order by magnitude, align the smaller operand
    // ------------------------------------------------------------------
    logic                   w_a_sign, w_b_sign;
    logic [EXP_W-1:0]       w_a_exp, w_b_exp;
    logic [MAN_W-1:0]       w_a_frac, w_b_frac;
    logic                   w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [EXP_W+MAN_W-1:0] w_a_mag, w_b_mag, w_l_mag, w_s_mag;
    logic                   w_swap, w_l_sign, w_s_sign;
    logic [EXP_W-1:0]       w_l_exp, w_s_exp, w_diff;
    logic [c_XW-1:0]        w_l_ext, w_s_ext, w_s_shift, w_s_aligned;
    logic                   w_s_lost;
    logic                   w_nan, w_inf, w_inf_sign, w_zero_sign;

    assign w_a_sign = a[EXP_W+MAN_W];
    assign w_b_sign = b[EXP_W+MAN_W] ^ operation;
    assign w_a_exp  = a[EXP_W+MAN_W-1:MAN_W];
    assign w_b_exp  = b[EXP_W+MAN_W-1:MAN_W];
    assign w_a_frac = a[MAN_W-1:0];
    assign w_b_frac = b[MAN_W-1:0];

    assign w_a_inf = (w_a_exp == c_EXP_ONES) && (w_a_frac == '0);
    assign w_b_inf = (w_b_exp == c_EXP_ONES) && (w_b_frac == '0);
    assign w_a_nan = (w_a_exp == c_EXP_ONES) && (w_a_frac != '0);
    assign w_b_nan = (w_b_exp == c_EXP_ONES) && (w_b_frac != '0);

    // Zero exponent (zero or subnormal) is treated as magnitude zero
    assign w_a_mag = (w_a_exp == '0) ? '0 : {w_a_exp, w_a_frac};
    assign w_b_mag = (w_b_exp == '0) ? '0 : {w_b_exp, w_b_frac};

    assign w_swap   = (w_b_mag > w_a_mag);
    assign w_l_mag  = w_swap ? w_b_mag  : w_a_mag;
    assign w_s_mag  = w_swap ? w_a_mag  : w_b_mag;
    assign w_l_sign = w_swap ? w_b_sign : w_a_sign;
    assign w_s_sign = w_swap ? w_a_sign : w_b_sign;
    assign w_l_exp  = w_l_mag[EXP_W+MAN_W-1:MAN_W];
    assign w_s_exp  = w_s_mag[EXP_W+MAN_W-1:MAN_W];
    assign w_diff   = w_l_exp - w_s_exp;

    assign w_l_ext = (w_l_exp == '0) ? '0 : {1'b1, w_l_mag[MAN_W-1:0], 3'b000};
    assign w_s_ext = (w_s_exp == '0) ? '0 : {1'b1, w_s_mag[MAN_W-1:0], 3'b000};

    // Bits shifted past the sticky position are OR-ed back into it; a
    // shift of c_XW or more leaves only the sticky bit.
    assign w_s_shift   = w_s_ext >> w_diff;
    assign w_s_lost    = |(w_s_ext & ~({c_XW{1'b1}} << w_diff));
    assign w_s_aligned = {w_s_shift[c_XW-1:1], w_s_shift[0] | w_s_lost};

    assign w_nan       = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_sign != w_b_sign));
    assign w_inf       = w_a_inf || w_b_inf;
    assign w_inf_sign  = w_a_inf ? w_a_sign : w_b_sign;
    // An exact zero sum is negative only when both addends are -0
    assign w_zero_sign = w_a_sign && w_b_sign;

    logic                   r_s1_valid, r_s1_nan, r_s1_inf, r_s1_inf_sign, r_s1_zero_sign;
    logic                   r_s1_sign, r_s1_sub;
    logic [EXP_W-1:0]       r_s1_exp;
    logic [c_XW-1:0]        r_s1_l_ext, r_s1_s_ext;
    logic [TAG_W-1:0]       r_s1_tag;

    // ------------------------------------------------------------------
    // Stage 2: effective add/subtract (larger minus smaller never borrows)
    // ------------------------------------------------------------------
    logic [c_XW:0] w_sum;
    assign w_sum = r_s1_sub ? ({1'b0, r_s1_l_ext} - {1'b0, r_s1_s_ext})
                            : ({1'b0, r_s1_l_ext} + {1'b0, r_s1_s_ext});

    logic                   r_s2_valid, r_s2_nan, r_s2_inf, r_s2_inf_sign, r_s2_zero_sign;
    logic                   r_s2_sign;
    logic [EXP_W-1:0]       r_s2_exp;
    logic [c_XW:0]          r_s2_sum;
    logic [TAG_W-1:0]       r_s2_tag;

    // ------------------------------------------------------------------
    // Stage 3: normalise, round to nearest even, resolve exceptions
    // ------------------------------------------------------------------
    logic [c_LZW-1:0] w_lzc;
    always_comb begin
        w_lzc = c_LZW'(c_XW);
        for (int i = 0; i < c_XW; i++) begin
            if (r_s2_sum[i]) w_lzc = c_LZW'(c_XW - 1 - i);
        end
    end

    logic                  w_sum_zero, w_carry;
    logic [c_XW-1:0]       w_norm;
    logic [c_EW-1:0]       w_exp_n, w_exp_r;
    logic                  w_g, w_r, w_st, w_rup, w_inexact;
    logic [c_MW-1:0]       w_mant;
    logic [MAN_W-1:0]      w_frac_r;
    logic                  w_ovf, w_unf;
    logic [EXP_W+MAN_W:0]  w_result;
    logic [4:0]            w_flags;

    assign w_sum_zero = (r_s2_sum == '0);
    assign w_carry    = r_s2_sum[c_XW];

    always_comb begin
        if (w_carry) begin
            // Carry out: shift right one place, folding the lost bit into sticky
            w_norm  = {r_s2_sum[c_XW:2], r_s2_sum[1] | r_s2_sum[0]};
            w_exp_n = c_EW'(r_s2_exp) + c_EW'(1);
        end else begin
            w_norm  = r_s2_sum[c_XW-1:0] << w_lzc;
            w_exp_n = c_EW'(r_s2_exp) - c_EW'(w_lzc);
        end
    end

    assign w_g       = w_norm[2];
    assign w_r       = w_norm[1];
    assign w_st      = w_norm[0];
    assign w_rup     = w_g && (w_r || w_st || w_norm[3]);
    assign w_inexact = w_g || w_r || w_st;
    assign w_mant    = {1'b0, w_norm[c_XW-1:3]} + c_MW'(w_rup);
    // Rounding carry renormalises: mantissa becomes 1.000..., exponent + 1
    assign w_exp_r   = w_exp_n + c_EW'(w_mant[MAN_W+1]);
    assign w_frac_r  = w_mant[MAN_W+1] ? w_mant[MAN_W:1] : w_mant[MAN_W-1:0];
    assign w_ovf     = !w_exp_r[c_EW-1] && (w_exp_r >= c_EXP_INF);
    assign w_unf     = w_exp_r[c_EW-1] || (w_exp_r == '0);

    always_comb begin
        w_result = {r_s2_sign, w_exp_r[EXP_W-1:0], w_frac_r};
        w_flags  = {4'b0000, w_inexact};
        if (r_s2_nan) begin
            w_result = {1'b0, c_EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            w_flags  = 5'b00010;
        end else if (r_s2_inf) begin
            w_result = {r_s2_inf_sign, c_EXP_ONES, {MAN_W{1'b0}}};
            w_flags  = 5'b00000;
        end else if (w_sum_zero) begin
            w_result = {r_s2_zero_sign, {(EXP_W+MAN_W){1'b0}}};
            w_flags  = 5'b00000;
        end else if (w_ovf) begin
            w_result = {r_s2_sign, c_EXP_ONES, {MAN_W{1'b0}}};
            w_flags  = 5'b10001;
        end else if (w_unf) begin
            w_result = {r_s2_sign, {(EXP_W+MAN_W){1'b0}}};
            w_flags  = 5'b01001;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers: every stage moves only when w_en is high
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid     <= 1'b0;
            r_s1_nan       <= 1'b0;
            r_s1_inf       <= 1'b0;
            r_s1_inf_sign  <= 1'b0;
            r_s1_zero_sign <= 1'b0;
            r_s1_sign      <= 1'b0;
            r_s1_sub       <= 1'b0;
            r_s1_exp       <= '0;
            r_s1_l_ext     <= '0;
            r_s1_s_ext     <= '0;
            r_s1_tag       <= '0;
            r_s2_valid     <= 1'b0;
            r_s2_nan       <= 1'b0;
            r_s2_inf       <= 1'b0;
            r_s2_inf_sign  <= 1'b0;
            r_s2_zero_sign <= 1'b0;
            r_s2_sign      <= 1'b0;
            r_s2_exp       <= '0;
            r_s2_sum       <= '0;
            r_s2_tag       <= '0;
            out_valid      <= 1'b0;
            result         <= '0;
            flags          <= '0;
            out_tag        <= '0;
        end else if (w_en) begin
            r_s1_valid     <= in_valid;
            r_s1_nan       <= w_nan;
            r_s1_inf       <= w_inf;
            r_s1_inf_sign  <= w_inf_sign;
            r_s1_zero_sign <= w_zero_sign;
            r_s1_sign      <= w_l_sign;
            r_s1_sub       <= (w_l_sign != w_s_sign);
            r_s1_exp       <= w_l_exp;
            r_s1_l_ext     <= w_l_ext;
            r_s1_s_ext     <= w_s_aligned;
            r_s1_tag       <= in_tag;
            r_s2_valid     <= r_s1_valid;
            r_s2_nan       <= r_s1_nan;
            r_s2_inf       <= r_s1_inf;
            r_s2_inf_sign  <= r_s1_inf_sign;
            r_s2_zero_sign <= r_s1_zero_sign;
            r_s2_sign      <= r_s1_sign;
            r_s2_exp       <= r_s1_exp;
            r_s2_sum       <= w_sum;
            r_s2_tag       <= r_s1_tag;
            out_valid      <= r_s2_valid;
            if (r_s2_valid) begin
                result  <= w_result;
                flags   <= w_flags;
                out_tag <= r_s2_tag;
            end
        end
    end

endmodule
`default_nettype wire
